// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Define PIPELINED_CSEL_ADDSUB_FLAGS_EN to build the {ovf, neg, zero} flags.
module pipelined_csel_addsub #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_adderOperand1,
   input  logic [WIDTH-1:0] i_adderOperand2,
   input  logic             i_cIn,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_adderSum,
   output logic             o_cOut,
   output logic [2:0]       o_flags
);
   localparam int NB  = WIDTH / BLOCK;
   localparam int BPS = NB / STAGES;

   logic [STAGES:0]              rdy;
   logic [STAGES-1:0][WIDTH-1:0] a_pipe;
   logic [STAGES-1:0][WIDTH-1:0] b_pipe;
   logic [STAGES-1:0][WIDTH-1:0] s_pipe;
   logic [STAGES-1:0]            c_pipe;
   logic [STAGES-1:0]            v_pipe;

   assign a_pipe[0]   = i_adderOperand1;
   assign b_pipe[0]   = i_sub ? ~i_adderOperand2 : i_adderOperand2;
   assign c_pipe[0]   = i_sub ? ~i_cIn : i_cIn;
   assign s_pipe[0]   = '0;
   assign v_pipe[0]   = i_valid;
   assign rdy[STAGES] = i_ready;
   assign o_ready     = rdy[0];

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_q;
      logic             c_d;
      logic             c_q;
      logic             v_q;
      logic             load;
      logic [BLOCK:0]   r0;
      logic [BLOCK:0]   r1;

      assign rdy[s] = ~v_q | rdy[s+1];
      assign load   = rdy[s] & v_pipe[s];

      // Both carry hypotheses per block, then a mux chain on the live carry.
      always_comb begin
         sum_d = s_pipe[s];
         c_d   = c_pipe[s];
         r0    = '0;
         r1    = '0;
         for (int k = s * BPS; k < (s + 1) * BPS; k++) begin
            r0 = {1'b0, a_pipe[s][k*BLOCK +: BLOCK]}
               + {1'b0, b_pipe[s][k*BLOCK +: BLOCK]};
            r1 = {1'b0, a_pipe[s][k*BLOCK +: BLOCK]}
               + {1'b0, b_pipe[s][k*BLOCK +: BLOCK]}
               + {{BLOCK{1'b0}}, 1'b1};
            sum_d[k*BLOCK +: BLOCK] = c_d ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            c_d = c_d ? r1[BLOCK] : r0[BLOCK];
         end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            v_q   <= 1'b0;
            sum_q <= '0;
            c_q   <= 1'b0;
         end else begin
            if (rdy[s]) v_q <= v_pipe[s];
            if (load) begin
               sum_q <= sum_d;
               c_q   <= c_d;
            end
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (load) begin
               a_q <= a_pipe[s];
               b_q <= b_pipe[s];
            end
         end

         assign a_pipe[s+1] = a_q;
         assign b_pipe[s+1] = b_q;
         assign s_pipe[s+1] = sum_q;
         assign c_pipe[s+1] = c_q;
         assign v_pipe[s+1] = v_q;
      end else begin : g_out
         assign o_valid    = v_q;
         assign o_adderSum = sum_q;
         assign o_cOut     = c_q;
`ifdef PIPELINED_CSEL_ADDSUB_FLAGS_EN
         logic [2:0] f_d;
         logic [2:0] f_q;

         assign f_d = {(a_pipe[s][WIDTH-1] == b_pipe[s][WIDTH-1])
                       & (sum_d[WIDTH-1] != a_pipe[s][WIDTH-1]),
                       sum_d[WIDTH-1],
                       ~|sum_d};

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) f_q <= 3'b000;
            else if (load) f_q <= f_d;
         end

         assign o_flags = f_q;
`else
         assign o_flags = 3'b000;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Bench for pipelined_csel_addsub: directed vectors, backpressure, reset
// and random traffic against an arithmetic model with an in-flight queue.
module tb_pipelined_csel_addsub;
   localparam int W   = 32;
   localparam int BLK = 4;
   localparam int ST  = 2;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic [2:0]   f;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         vld;
   logic         rdy_o;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         ovld;
   logic         rdy_i;
   logic [W-1:0] sum;
   logic         cout;
   logic [2:0]   flags;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   pipelined_csel_addsub #(
      .WIDTH (W),
      .BLOCK (BLK),
      .STAGES(ST)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_valid        (vld),
      .o_ready        (rdy_o),
      .i_adderOperand1(a),
      .i_adderOperand2(b),
      .i_cIn          (cin),
      .i_sub          (sub),
      .o_valid        (ovld),
      .i_ready        (rdy_i),
      .o_adderSum     (sum),
      .o_cOut         (cout),
      .o_flags        (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] a_,
                                  input logic [W-1:0] b_,
                                  input logic ci,
                                  input logic sb);
      exp_t         e;
      logic [W-1:0] be;
      logic         ce;
      logic [W:0]   r;
      be  = sb ? ~b_ : b_;
      ce  = sb ? ~ci : ci;
      r   = {1'b0, a_} + {1'b0, be} + {{W{1'b0}}, ce};
      e.s = r[W-1:0];
      e.c = r[W];
      e.f = {(a_[W-1] == be[W-1]) && (r[W-1] != a_[W-1]),
             r[W-1],
             r[W-1:0] == '0};
`ifndef PIPELINED_CSEL_ADDSUB_FLAGS_EN
      e.f = 3'b000;
`endif
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(5))
         0:       v = '0;
         1:       v = '1;
         2:       v = 32'h7FFF_FFFF;
         3:       v = 32'h8000_0000;
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare process: everything accepted and not yet emitted is in q.
   always @(negedge clk) begin : mon
      exp_t e;
      int   occ;
      logic er;
      if (rst) begin
         q.delete();
      end else begin
         occ = q.size();
         er  = !(occ == ST && !rdy_i);
         n_chk++;
         if (occ > ST || rdy_o !== er) begin
            n_err++;
            $display("FAIL o_ready: got %0b expected %0b (in flight %0d)",
                     rdy_o, er, occ);
         end
         if (ovld) begin
            if (occ == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL spurious o_valid: got 1 expected 0");
            end else begin
               e = q[0];
               chk("sum", 64'(sum), 64'(e.s));
               chk("cOut", 64'(cout), 64'(e.c));
               chk("flags", 64'(flags), 64'(e.f));
               if (rdy_i) void'(q.pop_front());
            end
         end
         if (vld && rdy_o) q.push_back(model(a, b, cin, sub));
      end
   end

   task automatic directed(input string nm,
                           input logic [W-1:0] a_, input logic [W-1:0] b_,
                           input logic ci, input logic sb,
                           input logic [W-1:0] es, input logic ec,
                           input logic [2:0] ef);
      int         n;
      logic [2:0] f;
      exp_t       e;
      f = ef;
`ifndef PIPELINED_CSEL_ADDSUB_FLAGS_EN
      f = 3'b000;
`endif
      e = model(a_, b_, ci, sb);
      chk({nm, " model sum"}, 64'(e.s), 64'(es));
      chk({nm, " model flags"}, 64'(e.f), 64'(f));
      chk({nm, " o_ready"}, 64'(rdy_o), 64'(1));
      a = a_; b = b_; cin = ci; sub = sb; vld = 1'b1;
      step();
      vld = 1'b0;
      n = 1;
      while (!ovld && n < 4 * ST + 4) begin
         step();
         n++;
      end
      chk({nm, " latency"}, 64'(n), 64'(ST));
      chk({nm, " sum"}, 64'(sum), 64'(es));
      chk({nm, " cOut"}, 64'(cout), 64'(ec));
      chk({nm, " flags"}, 64'(flags), 64'(f));
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      vld = 1'b0;
      rdy_i = 1'b1;
      while ((q.size() != 0 || ovld) && n < 40) begin
         step();
         n++;
      end
      chk({nm, " drained"}, 64'(q.size()), 64'(0));
   endtask

   initial begin
      int           acc;
      logic         have;
      logic [W-1:0] held;
      rst = 1'b1; vld = 1'b0; rdy_i = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset o_valid", 64'(ovld), 64'(0));
      chk("reset sum", 64'(sum), 64'(0));
      chk("reset cOut", 64'(cout), 64'(0));
      chk("reset flags", 64'(flags), 64'(0));
      chk("reset o_ready", 64'(rdy_o), 64'(1));
      rst = 1'b0;
      step();

      directed("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h0, 1'b1, 3'b001);
      directed("sub5-7", 32'h5, 32'h7, 1'b0, 1'b1,
               32'hFFFF_FFFE, 1'b0, 3'b010);
      directed("ovf add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 3'b110);
      directed("sub borrow", 32'hA, 32'h3, 1'b1, 1'b1,
               32'h6, 1'b1, 3'b000);
      directed("add cin", 32'hF, 32'h1, 1'b1, 1'b0,
               32'h11, 1'b0, 3'b000);
      directed("ovf sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
               32'h7FFF_FFFF, 1'b1, 3'b100);
      drain("directed");

      rdy_i = 1'b1;
      for (int i = 0; i < 8 + ST - 1; i++) begin
         if (i < 8) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            vld = 1'b1;
            chk("b2b o_ready", 64'(rdy_o), 64'(1));
         end else begin
            vld = 1'b0;
         end
         step();
         if (i >= ST - 1) chk("b2b o_valid", 64'(ovld), 64'(1));
      end
      drain("b2b");

      rdy_i = 1'b0;
      acc = 0;
      have = 1'b0;
      held = '0;
      for (int i = 0; i < 5; i++) begin
         a = pick(); b = pick();
         cin = 1'($urandom); sub = 1'($urandom);
         vld = 1'b1;
         if (rdy_o) acc++;
         step();
         if (ovld && !have) begin
            held = sum;
            have = 1'b1;
         end
      end
      vld = 1'b0;
      chk("bp accepts", 64'(acc), 64'(ST));
      chk("bp o_ready", 64'(rdy_o), 64'(0));
      chk("bp o_valid", 64'(ovld), 64'(1));
      chk("bp held sum", 64'(sum), 64'(held));
      drain("bp");

      rdy_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a = W'($urandom); b = W'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         vld = 1'b1;
         step();
      end
      vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst o_valid", 64'(ovld), 64'(0));
      chk("rst sum", 64'(sum), 64'(0));
      chk("rst cOut", 64'(cout), 64'(0));
      chk("rst flags", 64'(flags), 64'(0));
      chk("rst o_ready", 64'(rdy_o), 64'(1));
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post-rst o_valid", 64'(ovld), 64'(0));
      end

      for (int i = 0; i < 1500; i++) begin
         vld = ($urandom_range(9) < 7);
         rdy_i = ($urandom_range(9) < 7);
         a = pick(); b = pick();
         cin = 1'($urandom); sub = 1'($urandom);
         step();
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
